score_display: RTL and testbench

//  Consumer end of the score counter: takes the 4-digit BCD score bus (digit 0 = bits [3:0], LS digit),

---
 rtl/score_display.sv | 123 ++++++++++++
 tb/tb_score_display.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/score_display.sv
// Score display: holds the BCD score and high score, drives a multiplexed 4-digit 7-segment display.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module score_display #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] score,
    input  logic        upd,
    input  logic        commit,
    input  logic        show_hi,
    output logic        new_record,
    output logic [15:0] hi_score,
    output logic [3:0]  an,
    output logic [7:0]  seg
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_TC = PW'(SCAN_DIV - 1);

    function automatic logic [6:0] decode_digit(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    logic [15:0]   score_reg_q, score_reg_d;
    logic [15:0]   hi_score_q, hi_score_d;
    logic          new_record_q, new_record_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    an_q, an_d;
    logic [7:0]    seg_q, seg_d;
    logic [15:0]   disp_val;
    logic [3:0]    digit_sel;
    logic          blank;

    // Next-state logic: capture, high-score commit, scan timing and segment decode
    always_comb begin
        if (upd) begin
            score_reg_d = score;
        end else begin
            score_reg_d = score_reg_q;
        end

        // Commit compares the pre-update score so upd+commit in one cycle uses the old value
        if (commit && (score_reg_q > hi_score_q)) begin
            hi_score_d   = score_reg_q;
            new_record_d = 1'b1;
        end else begin
            hi_score_d   = hi_score_q;
            new_record_d = 1'b0;
        end

        if (presc_q == PRESC_TC) begin
            presc_d = '0;
            idx_d   = idx_q + 2'd1;
        end else begin
            presc_d = presc_q + PW'(1);
            idx_d   = idx_q;
        end

        disp_val  = show_hi ? hi_score_q : score_reg_q;
        digit_sel = disp_val[{idx_q, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
        case (idx_q)
            2'd3:    blank = (disp_val[15:12] == 4'h0);
            2'd2:    blank = (disp_val[15:8] == 8'h00);
            2'd1:    blank = (disp_val[15:4] == 12'h000);
            default: blank = 1'b0;
        endcase
`else
        blank = 1'b0;
`endif

        an_d = ~(4'b0001 << idx_q);
        if (blank) begin
            seg_d = 8'hFF;
        end else begin
            seg_d = {1'b1, decode_digit(digit_sel)};
        end
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score_reg_q  <= 16'h0000;
            hi_score_q   <= 16'h0000;
            new_record_q <= 1'b0;
            presc_q      <= '0;
            idx_q        <= 2'd0;
            an_q         <= 4'b1111;
            seg_q        <= 8'hFF;
        end else begin
            score_reg_q  <= score_reg_d;
            hi_score_q   <= hi_score_d;
            new_record_q <= new_record_d;
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
        end
    end

    assign new_record = new_record_q;
    assign hi_score   = hi_score_q;
    assign an         = an_q;
    assign seg        = seg_q;

endmodule

// File: tb/tb_score_display.sv
// Scoreboard bench for score_display (SCAN_DIV=4): expectations queued per cycle, checked on negedge.
module tb_score_display;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] score = 16'h0000;
    logic        upd = 1'b0;
    logic        commit = 1'b0;
    logic        show_hi = 1'b0;
    logic        new_record;
    logic [15:0] hi_score;
    logic [3:0]  an;
    logic [7:0]  seg;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [7:0] Z = 8'hFF;
`else
    localparam logic [7:0] Z = 8'hC0;
`endif

    typedef struct {
        string       name;
        int          tgt;
        logic [3:0]  an;
        logic [7:0]  seg;
        logic [15:0] hi;
        logic        nr;
    } exp_t;

    exp_t exp_q[$];
    exp_t it;
    int   cnt = 0;
    int   checks = 0;
    int   errors = 0;

    score_display #(.SCAN_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .score(score), .upd(upd), .commit(commit),
        .show_hi(show_hi), .new_record(new_record), .hi_score(hi_score), .an(an), .seg(seg)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst_n) cnt <= 0;
        else        cnt <= cnt + 1;
    end

    // Monitor: pops every expectation due at this cycle and compares
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].tgt <= cnt) begin
            it = exp_q.pop_front();
            checks = checks + 1;
            if (it.tgt != cnt || an !== it.an || seg !== it.seg || hi_score !== it.hi || new_record !== it.nr) begin
                errors = errors + 1;
                $display("FAIL %s cyc=%0d (due %0d): got an=%b seg=%h hi=%h nr=%b, expected an=%b seg=%h hi=%h nr=%b",
                         it.name, cnt, it.tgt, an, seg, hi_score, new_record, it.an, it.seg, it.hi, it.nr);
            end
        end
    end

    function automatic logic [31:0] s4(input logic [7:0] d3, input logic [7:0] d2,
                                       input logic [7:0] d1, input logic [7:0] d0);
        return {d3, d2, d1, d0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string nm, input int tgt, input logic [3:0] a,
                        input logic [7:0] s, input logic [15:0] h, input logic n);
        exp_t e;
        e.name = nm; e.tgt = tgt; e.an = a; e.seg = s; e.hi = h; e.nr = n;
        exp_q.push_back(e);
    endtask

    // Queue ncyc cycles of scan expectations; first cycle still shows old_segs (registered source)
    task automatic run(input string nm, input logic [31:0] segs, input logic [31:0] old_segs,
                       input logic [15:0] hi, input logic nr1, input int ncyc);
        logic [31:0] s;
        logic [3:0]  a;
        for (int k = 1; k <= ncyc; k++) begin
            int n;
            int d;
            n = cnt + k;
            d = ((n - 1) / 4) % 4;
            s = (k == 1) ? old_segs : segs;
            a = ~(4'b0001 << d);
            push(nm, n, a, s[8*d +: 8], hi, (k == 1) ? nr1 : 1'b0);
        end
        tick();
        upd = 1'b0;
        commit = 1'b0;
        repeat (ncyc - 1) tick();
    endtask

    logic [31:0] s0000, s1234, s0150, s0099, s0200, s0300, s00a7, sf000;

    initial begin
        s0000 = s4(Z, Z, Z, 8'hC0);
        s1234 = s4(8'hF9, 8'hA4, 8'hB0, 8'h99);
        s0150 = s4(Z, 8'hF9, 8'h92, 8'hC0);
        s0099 = s4(Z, Z, 8'h90, 8'h90);
        s0200 = s4(Z, 8'hA4, 8'hC0, 8'hC0);
        s0300 = s4(Z, 8'hB0, 8'hC0, 8'hC0);
        s00a7 = s4(Z, Z, 8'hBF, 8'hF8);
        sf000 = s4(8'h8E | 8'h31, 8'hC0, 8'hC0, 8'hC0);

        push("reset_state", 0, 4'b1111, 8'hFF, 16'h0000, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        run("scan_after_reset", s0000, s0000, 16'h0000, 1'b0, 20);

        score = 16'h1234; upd = 1'b1;
        run("capture_1234", s1234, s0000, 16'h0000, 1'b0, 16);

        score = 16'h0150; upd = 1'b1;
        run("capture_0150", s0150, s1234, 16'h0000, 1'b0, 4);
        commit = 1'b1;
        run("commit_record", s0150, s0150, 16'h0150, 1'b1, 4);
        commit = 1'b1;
        run("commit_equal", s0150, s0150, 16'h0150, 1'b0, 4);

        score = 16'h0099; upd = 1'b1;
        run("capture_0099", s0099, s0150, 16'h0150, 1'b0, 4);
        commit = 1'b1;
        run("commit_lower", s0099, s0099, 16'h0150, 1'b0, 4);

        score = 16'h0200; upd = 1'b1;
        run("capture_0200", s0200, s0099, 16'h0150, 1'b0, 4);
        score = 16'h0300; upd = 1'b1; commit = 1'b1;
        run("upd_commit_same", s0300, s0200, 16'h0200, 1'b1, 8);

        show_hi = 1'b1;
        run("show_hi_on", s0200, s0200, 16'h0200, 1'b0, 8);
        show_hi = 1'b0;
        run("show_hi_off", s0300, s0300, 16'h0200, 1'b0, 4);

        score = 16'h00A7; upd = 1'b1;
        run("invalid_digit_a7", s00a7, s0300, 16'h0200, 1'b0, 16);
        score = 16'hF000; upd = 1'b1;
        run("invalid_top_digit", sf000, s00a7, 16'h0200, 1'b0, 16);

        for (int i = 0; i < 40 && !(cnt > 0 && ((cnt - 1) / 4) % 4 == 2 && (cnt - 1) % 4 == 1); i++) tick();
        checks = checks + 1;
        if (!(cnt > 0 && ((cnt - 1) / 4) % 4 == 2 && (cnt - 1) % 4 == 1)) begin
            errors = errors + 1;
            $display("FAIL wait_digit2: scan position cnt=%0d, required mid digit 2", cnt);
        end
        rst_n = 1'b0;
        push("async_reset", cnt, 4'b1111, 8'hFF, 16'h0000, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        run("scan_restart", s0000, s0000, 16'h0000, 1'b0, 8);

        tick();
        tick();
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL queue_drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
